// File: rtl/dea_stream_controller_pkg.sv
// Shared types and constants for the DEA stream controller.
// Holds the FSM encodings, key ring geometry and the active-key clamp.
package dea_stream_controller_pkg;

  localparam int KEY_DEPTH = 16;
  localparam int KEY_AW    = 4;
  localparam int BW        = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [KEY_AW:0] KEY_MAX = (KEY_AW+1)'(KEY_DEPTH);

  typedef logic [BW-1:0] byte_t;

  typedef struct packed {
    byte_t           size;
    logic [KEY_AW:0] nkeys;
  } cfg_t;

  // Zero keys means one key; anything past the ring size uses the whole ring.
  function automatic logic [KEY_AW:0] eff_keys(
    input logic [KEY_AW:0] n
  );
    if (n == '0)
      return (KEY_AW+1)'(1);
    if (n > KEY_MAX)
      return KEY_MAX;
    return n;
  endfunction

endpackage

// File: rtl/dea_stream_controller_if.sv
// Bundle of host, key, stream and datapath signals for the controller.
// master is the controller side, slave is the surrounding system.
interface dea_stream_controller_if;
  import dea_stream_controller_pkg::*;

  logic              Start;
  byte_t             Id;
  byte_t             SizeOfData;
  logic [KEY_AW:0]   NumberOfKeys;
  logic              KeyWe;
  logic [KEY_AW-1:0] KeyAddr;
  byte_t             KeyData;
  byte_t             InData;
  logic              InValid;
  logic              InReady;
  byte_t             EncDataIn;
  byte_t             EncKey;
  logic              EncAck;
  byte_t             EncDataOut;
  logic              EncReady;
  byte_t             OutData;
  byte_t             OutId;
  logic              OutLast;
  logic              OutValid;
  logic              OutReady;
  logic              Busy;
  logic              Done;

  modport master (
    input  Start, Id, SizeOfData, NumberOfKeys,
    input  KeyWe, KeyAddr, KeyData,
    input  InData, InValid,
    output InReady,
    output EncDataIn, EncKey, EncAck,
    input  EncDataOut, EncReady,
    output OutData, OutId, OutLast, OutValid,
    input  OutReady,
    output Busy, Done
  );

  modport slave (
    output Start, Id, SizeOfData, NumberOfKeys,
    output KeyWe, KeyAddr, KeyData,
    output InData, InValid,
    input  InReady,
    input  EncDataIn, EncKey, EncAck,
    output EncDataOut, EncReady,
    input  OutData, OutId, OutLast, OutValid,
    output OutReady,
    input  Busy, Done
  );

endinterface

// File: rtl/dea_stream_controller_key_ring.sv
// Key register file with a read index that wraps at the active key count.
// Writes are synchronous, the current key is read combinationally.
module dea_stream_controller_key_ring
  import dea_stream_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [KEY_AW-1:0] waddr,
  input  byte_t             wdata,
  input  logic [KEY_AW:0]   nkeys,
  input  logic              clr,
  input  logic              adv,
  output byte_t             key
);

  byte_t             ring [KEY_DEPTH];
  logic [KEY_AW-1:0] idx;
  logic [KEY_AW:0]   last_idx;

  assign last_idx = eff_keys(nkeys) - (KEY_AW+1)'(1);
  assign key      = ring[idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_DEPTH; i++)
        ring[i] <= '0;
      idx <= '0;
    end else begin
      if (we)
        ring[waddr] <= wdata;
      if (clr)
        idx <= '0;
      else if (adv)
        idx <= ({1'b0, idx} == last_idx) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/dea_stream_controller.sv
// Sequences a message byte by byte through the XOR datapath.
// Fetch, encrypt, capture, emit; the datapath is parked with Ack high.
module dea_stream_controller
  import dea_stream_controller_pkg::*;
(
  input  logic Clk,
  input  logic Rst_n,
  dea_stream_controller_if.master bus
);

  logic [2:0] state;
  cfg_t       cfg;
  byte_t      byte_cnt;
  byte_t      data_q;
  byte_t      key_q;
  byte_t      out_data;
  byte_t      out_id;
  logic       out_last;
  logic       out_valid;
  byte_t      key;
  logic       ring_we;
  logic       idx_clr;
  logic       idx_adv;
  logic       is_last;

  // Key writes and Start are only honoured while idle.
  assign ring_we = (state == S_IDLE) && bus.KeyWe;
  assign idx_clr = (state == S_IDLE) && bus.Start;
  assign idx_adv = (state == S_EMIT) && bus.OutReady;
  assign is_last = (byte_cnt == cfg.size - 8'd1);

  dea_stream_controller_key_ring u_ring (
    .clk   (Clk),
    .rst_n (Rst_n),
    .we    (ring_we),
    .waddr (bus.KeyAddr),
    .wdata (bus.KeyData),
    .nkeys (cfg.nkeys),
    .clr   (idx_clr),
    .adv   (idx_adv),
    .key   (key)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      cfg       <= '0;
      byte_cnt  <= '0;
      data_q    <= '0;
      key_q     <= '0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.Start) begin
            cfg.size  <= bus.SizeOfData;
            cfg.nkeys <= bus.NumberOfKeys;
            out_id    <= bus.Id;
            byte_cnt  <= '0;
            state     <= (bus.SizeOfData == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.InValid) begin
            data_q <= bus.InData;
            key_q  <= key;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          state <= S_CAPT;
        end
        S_CAPT: begin
          if (bus.EncReady) begin
            out_data  <= bus.EncDataOut;
            out_last  <= is_last;
            out_valid <= 1'b1;
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.OutReady) begin
            out_valid <= 1'b0;
            byte_cnt  <= byte_cnt + 8'd1;
            state     <= out_last ? S_DONE : S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.InReady   = (state == S_FETCH);
  assign bus.EncAck    = !((state == S_WAIT) || (state == S_CAPT));
  assign bus.EncDataIn = data_q;
  assign bus.EncKey    = key_q;
  assign bus.OutData   = out_data;
  assign bus.OutId     = out_id;
  assign bus.OutLast   = out_last;
  assign bus.OutValid  = out_valid;
  assign bus.Busy      = (state != S_IDLE);
  assign bus.Done      = (state == S_DONE);

endmodule

// File: tb/tb_dea_stream_controller.sv
// Bench for dea_stream_controller with a behavioural XOR datapath.
// Expected ciphertext comes from in[i] ^ key[i mod active_keys].
module tb_dea_stream_controller;
  import dea_stream_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dea_stream_controller_if bus ();

  dea_stream_controller dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  // Datapath: computes while Ack is low, Ready drops while parked.
  always @(posedge clk) begin
    if (!bus.EncAck) begin
      bus.EncDataOut <= bus.EncDataIn ^ bus.EncKey;
      bus.EncReady   <= 1'b1;
    end else begin
      bus.EncReady   <= 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;

  logic [7:0] ring_m [KEY_DEPTH];
  logic [7:0] din_q [$];

  int         rnd_gaps;
  int         stall_at;
  int         stall_len;
  int         abort_at;
  int         poke_cyc;
  bit         pre_we;
  logic [3:0] pre_addr;
  logic [7:0] pre_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  32'(bus.InReady),   32'd0);
    chk({tag, "_enc_ack"},   32'(bus.EncAck),    32'd1);
    chk({tag, "_enc_din"},   32'(bus.EncDataIn), 32'd0);
    chk({tag, "_enc_key"},   32'(bus.EncKey),    32'd0);
    chk({tag, "_out_data"},  32'(bus.OutData),   32'd0);
    chk({tag, "_out_id"},    32'(bus.OutId),     32'd0);
    chk({tag, "_out_last"},  32'(bus.OutLast),   32'd0);
    chk({tag, "_out_valid"}, 32'(bus.OutValid),  32'd0);
    chk({tag, "_busy"},      32'(bus.Busy),      32'd0);
    chk({tag, "_done"},      32'(bus.Done),      32'd0);
  endtask

  task automatic defaults();
    rnd_gaps  = 0;
    stall_at  = -1;
    stall_len = 0;
    abort_at  = 0;
    poke_cyc  = -1;
    pre_we    = 1'b0;
  endtask

  task automatic write_key(input logic [3:0] a, input logic [7:0] d);
    bus.KeyWe   = 1'b1;
    bus.KeyAddr = a;
    bus.KeyData = d;
    @(negedge clk);
    bus.KeyWe   = 1'b0;
    ring_m[a]   = d;
  endtask

  task automatic fill_random(input int n);
    din_q.delete();
    for (int i = 0; i < n; i++)
      din_q.push_back(8'($urandom));
  endtask

  task automatic run_msg(input logic [7:0] id, input logic [KEY_AW:0] nk);
    logic [7:0] exp [$];
    int         acc_cyc [$];
    int         sz, eff, sent, rcv, cyc, dones, acks;
    int         stall_cnt, done_cyc, budget;
    bit         fin, seen, iv;
    logic       ordy;
    sz = din_q.size();
    if (pre_we)
      ring_m[pre_addr] = pre_data;
    eff = (nk == '0) ? 1 : ((int'(nk) > KEY_DEPTH) ? KEY_DEPTH : int'(nk));
    for (int i = 0; i < sz; i++)
      exp.push_back(din_q[i] ^ ring_m[i % eff]);
    sent = 0; rcv = 0; dones = 0; acks = 0;
    stall_cnt = 0; done_cyc = -1; fin = 0; seen = 0;
    budget = 60 + sz * 40 + stall_len;
    bus.Start        = 1'b1;
    bus.Id           = id;
    bus.SizeOfData   = 8'(sz);
    bus.NumberOfKeys = nk;
    bus.InValid      = 1'b0;
    bus.OutReady     = 1'b1;
    if (pre_we) begin
      bus.KeyWe   = 1'b1;
      bus.KeyAddr = pre_addr;
      bus.KeyData = pre_data;
    end
    @(negedge clk);
    bus.Start        = 1'b0;
    bus.KeyWe        = 1'b0;
    bus.Id           = 8'($urandom);
    bus.SizeOfData   = 8'($urandom);
    bus.NumberOfKeys = 5'($urandom);
    cyc = 1;
    while (!fin && cyc < budget) begin
      if (abort_at != 0 && sent == abort_at && bus.EncAck === 1'b0) begin
        rst_n       = 1'b0;
        bus.InValid = 1'b0;
        @(negedge clk);
        chk_reset("abort");
        chk("abort_done_count", 32'(dones), 32'd0);
        rst_n = 1'b1;
        foreach (ring_m[i]) ring_m[i] = '0;
        return;
      end
      if (bus.Done) begin
        dones++;
        done_cyc = cyc;
        fin = 1;
      end
      if (!bus.EncAck)
        acks++;
      if (sent >= sz)
        chk("in_ready_extra", 32'(bus.InReady), 32'd0);
      ordy = 1'b1;
      if (rcv >= sz) begin
        chk("out_valid_extra", 32'(bus.OutValid), 32'd0);
      end else if (bus.OutValid) begin
        chk("out_data", 32'(bus.OutData), 32'(exp[rcv]));
        chk("out_id", 32'(bus.OutId), 32'(id));
        chk("out_last", 32'(bus.OutLast), 32'(rcv == sz - 1));
        chk("in_ready_emit", 32'(bus.InReady), 32'd0);
        chk("ack_emit", 32'(bus.EncAck), 32'd1);
        if (!seen && rcv < acc_cyc.size()) begin
          chk("latency", 32'(cyc), 32'(acc_cyc[rcv] + 3));
          seen = 1;
        end
        if (rcv == stall_at && stall_cnt < stall_len) begin
          ordy = 1'b0;
          stall_cnt++;
        end else if (rnd_gaps != 0) begin
          ordy = ($urandom_range(0, 3) != 0);
        end
        if (ordy) begin
          rcv++;
          seen = 0;
        end
      end
      bus.OutReady = ordy;
      if (sent < sz) begin
        iv = (rnd_gaps != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.InValid = iv;
        bus.InData  = iv ? din_q[sent] : 8'($urandom);
        if (iv && bus.InReady) begin
          acc_cyc.push_back(cyc);
          sent++;
        end
      end else begin
        bus.InValid = 1'b0;
        bus.InData  = 8'($urandom);
      end
      if (cyc == poke_cyc) begin
        bus.Start   = 1'b1;
        bus.Id      = ~id;
        bus.KeyWe   = 1'b1;
        bus.KeyAddr = '0;
        bus.KeyData = 8'hEE;
      end else begin
        bus.Start = 1'b0;
        bus.KeyWe = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.Start   = 1'b0;
    bus.KeyWe   = 1'b0;
    bus.InValid = 1'b0;
    chk("timeout", 32'(fin), 32'd1);
    chk("done_count", 32'(dones), 32'd1);
    chk("bytes_out", 32'(rcv), 32'(sz));
    chk("bytes_in", 32'(sent), 32'(sz));
    chk("ack_low_cycles", 32'(acks), 32'(2 * sz));
    if (sz == 0)
      chk("done_lat_zero", 32'(done_cyc >= 1 && done_cyc <= 2), 32'd1);
    chk("busy_after", 32'(bus.Busy), 32'd0);
    chk("done_after", 32'(bus.Done), 32'd0);
  endtask

  initial begin
    defaults();
    foreach (ring_m[i]) ring_m[i] = '0;
    bus.Start        = 1'b0;
    bus.Id           = '0;
    bus.SizeOfData   = '0;
    bus.NumberOfKeys = '0;
    bus.KeyWe        = 1'b0;
    bus.KeyAddr      = '0;
    bus.KeyData      = '0;
    bus.InData       = '0;
    bus.InValid      = 1'b0;
    bus.OutReady     = 1'b1;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Three-key ring over a five-byte ramp
    write_key(4'd0, 8'h11);
    write_key(4'd1, 8'h22);
    write_key(4'd2, 8'h33);
    din_q.delete();
    for (int i = 0; i < 5; i++)
      din_q.push_back(8'(i));
    run_msg(8'h7A, 5'd3);

    // Empty message
    din_q.delete();
    run_msg(8'h01, 5'd2);

    // N=0 acts as a single key
    write_key(4'd0, 8'hFF);
    din_q.delete();
    repeat (3) din_q.push_back(8'hA5);
    run_msg(8'h33, 5'd0);

    // Downstream stall on the second byte
    for (int i = 0; i < KEY_DEPTH; i++)
      write_key(4'(i), 8'($urandom));
    fill_random(6);
    stall_at  = 1;
    stall_len = 10;
    run_msg(8'hC4, 5'd5);
    defaults();

    // Reset during WAIT of the third byte, then a clean message
    fill_random(6);
    abort_at = 3;
    run_msg(8'h5E, 5'd4);
    defaults();
    @(negedge clk);
    fill_random(4);
    run_msg(8'h42, 5'd2);

    // Key write and Start while busy are ignored
    for (int i = 0; i < 4; i++)
      write_key(4'(i), 8'($urandom));
    fill_random(8);
    poke_cyc = 6;
    run_msg(8'h9B, 5'd4);
    defaults();

    // Key write and Start together while idle
    fill_random(3);
    pre_we   = 1'b1;
    pre_addr = 4'd0;
    pre_data = 8'h5C;
    run_msg(8'h77, 5'd1);
    defaults();

    // Randomised messages with handshake gaps
    for (int i = 0; i < KEY_DEPTH; i++)
      write_key(4'(i), 8'($urandom));
    rnd_gaps = 1;
    for (int t = 0; t < 6; t++) begin
      fill_random($urandom_range(1, 24));
      run_msg(8'($urandom), 5'($urandom_range(0, 31)));
    end
    defaults();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
